viterbi_channel_model: RTL and testbench
========================================

# viterbi_channel_model

Parametrised, cycle-accurate channel model inserted between the convolutional encoder and the Viterbi decoder. It passes W-bit coded symbols through with one cycle of latency and flips selected bits according to a run-time mode: clean, periodic bursts, random single errors or random bursts. It keeps symbol, bit-flip and burst statistics so benches can correlate decoder output against injected damage.

## Interface
- W, 2: bits per coded symbol (1/W code rate).
- N, 5: random-trigger rate; a trigger fires when LFSR[N-1:0]==0, probability 2^-N; N=0 means always.
- PERIOD, 32: periodic-mode cycle length in symbols; must be at least 1.
- BURST_LEN, 2: symbols per burst; 1 ≤ BURST_LEN ≤ PERIOD.
- WINDOW, 256: injection is allowed only while sym_ct_o < WINDOW; 0 means unlimited.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode_i  in  2  0 clean, 1 periodic burst, 2 random single, 3 random burst.
- mask_i  in  W  bits XORed into a corrupted symbol.
- valid_i  in  1  sym_i valid this cycle.
- sym_i  in  W  encoder symbol.
- valid_o  out  1  registered valid_i.
- sym_o  out  W  symbol to the decoder, possibly corrupted.
- err_o  out  1  sym_o was corrupted; meaningful only when valid_o=1.
- sym_ct_o  out  32  valid symbols seen; saturates at 2^32-1.
- flip_ct_o  out  32  total bits flipped; saturates.
- burst_ct_o  out  16  burst/trigger starts; saturates.

## Operation
- Only cycles with valid_i=1 are symbol events. With valid_i=0, state, LFSR, phase and counters all hold.
- The injection-enable condition inj_en is true when mode_i≠0 and either WINDOW==0 or sym_ct_o < WINDOW. sym_ct_o is evaluated before its increment.
- phase: modulo-PERIOD counter of symbol events, reset to 0. It advances in every mode.
- LFSR: 16-bit Galois, mask 0xB400. It shifts once per symbol event. The trigger test uses the pre-shift value.
- The trigger for a symbol event depends on the mode:
  - Mode 1: trigger when phase == PERIOD-BURST_LEN.
  - Mode 2: trigger on the LFSR condition.
  - Mode 3: trigger on the LFSR condition.
- FSM IDLE:
  - On a symbol event with inj_en and a trigger: corrupt this symbol and increment burst_ct.
  - Then go to BURST with rem=BURST_LEN-1 in modes 1 and 3 when BURST_LEN>1.
  - Mode 2 always stays in IDLE.
- FSM BURST:
  - On each symbol event with inj_en: corrupt the symbol and decrement rem.
  - Return to IDLE when rem reaches 0.
  - If inj_en is false (mode 0 or window expired), go to IDLE immediately and do not corrupt that symbol.
- A mode change between modes 1 and 3 during a burst lets the burst finish. Changing to mode 2 also finishes the remaining burst.
- Corruption: sym_o = sym_i ^ mask_i, err_o=1, and flip_ct += popcount(mask_i). A corrupted symbol with mask_i=0 still sets err_o but adds 0 flips.
- Uncorrupted symbol: sym_o = sym_i, err_o=0.
- A trigger arriving while in BURST is ignored; it is not queued.

## Timing
- Latency is 1 cycle: valid_o, sym_o and err_o are registered from the cycle-n inputs and appear at cycle n+1.
- Counters, phase, LFSR and FSM update on the same edge as the outputs.
- Reset (asynchronous, any time, including mid-burst) sets:
  - valid_o=0, sym_o=0, err_o=0.
  - All counters 0, phase=0, LFSR=SEED, state IDLE, rem=0.
- Operation resumes on the first rising edge after rst deasserts.
- Back-to-back valid_i is supported at full rate. There is no backpressure.
- Outputs hold their last values while valid_o=0, except that valid_o itself is 0.

## Test plan
- Mode 0, 300 contiguous symbols counting 0..3 mod 4:
  - Required: sym_o equals sym_i delayed by 1 cycle.
  - err_o is never set, flip_ct_o=0, burst_ct_o=0, sym_ct_o=300.
- Mode 1 with defaults, mask_i=2'b11, 300 symbols:
  - Required: only symbols 30,31,62,63,…,254,255 are inverted.
  - flip_ct_o=32 and burst_ct_o=8. No errors occur after symbol 255.
- Mode 2 with N=0, mask_i=2'b01, WINDOW=256, 260 symbols:
  - Required: symbols 0–255 have bit0 flipped; symbols 256–259 are clean.
  - flip_ct_o=256 and burst_ct_o=256.
- Mode 3 with N=0, BURST_LEN=3, mask_i=2'b10, 256 symbols:
  - Required: every symbol is corrupted.
  - burst_ct_o=86, since bursts start at symbols 0,3,…,255.
- Mode 1 with valid_i toggling 1/0:
  - Required: phase advances only on valid cycles, so corruption lands on the same symbol indices as the contiguous case.
  - valid_o mirrors valid_i delayed by 1 cycle.
- Mode 3 with N=0, BURST_LEN=4. At symbol 1, either switch to mode 0 or assert rst:
  - Mode 0 case: symbol 1 is clean and the FSM is in IDLE.
  - rst case: all outputs and counters are 0 and LFSR=16'hACE1.

Source files
------------

// File: rtl/viterbi_channel_model.sv
// Channel model between the convolutional encoder and the Viterbi decoder.
// Passes W-bit coded symbols through with one cycle of latency, corrupting
// selected symbols according to mode_i, and keeps symbol/flip/burst counts.
// Handshake: valid_i qualifies sym_i for one cycle; there is no ready, every
// valid cycle is consumed. valid_o is valid_i delayed by one cycle, and
// sym_o/err_o hold their last values while valid_o is low.
module viterbi_channel_model #(
    parameter int unsigned W         = 2,
    parameter int unsigned N         = 5,
    parameter int unsigned PERIOD    = 32,
    parameter int unsigned BURST_LEN = 2,
    parameter int unsigned WINDOW    = 256,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode_i,
    input  logic [W-1:0] mask_i,
    input  logic         valid_i,
    input  logic [W-1:0] sym_i,
    output logic         valid_o,
    output logic [W-1:0] sym_o,
    output logic         err_o,
    output logic [31:0]  sym_ct_o,
    output logic [31:0]  flip_ct_o,
    output logic [15:0]  burst_ct_o,
    output logic         dbg_state_o,
    output logic [15:0]  dbg_lfsr_o
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned RW = $clog2(BURST_LEN + 1);
    localparam logic [15:0]   TRIG_MASK  = 16'((32'd1 << N) - 32'd1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PHASE_TRIG = PW'(PERIOD - BURST_LEN);
    localparam logic [RW-1:0] REM_INIT   = RW'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [RW-1:0] rem, rem_nx;
    logic [PW-1:0] phase, phase_nx;
    logic [15:0]   lfsr, lfsr_nx;
    logic          inj_en, trig, corrupt, burst_start;
    logic [31:0]   flip_add;
    logic [32:0]   flip_sum;

    assign dbg_state_o = (state == S_BURST);
    assign dbg_lfsr_o  = lfsr;

    // Injection is gated by mode and by the symbol window (pre-increment count).
    assign inj_en   = (mode_i != 2'd0) && ((WINDOW == 0) || (sym_ct_o < 32'(WINDOW)));
    assign lfsr_nx  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign phase_nx = (phase == PHASE_LAST) ? '0 : phase + 1'b1;
    assign flip_add = 32'($countones(mask_i));
    assign flip_sum = {1'b0, flip_ct_o} + {1'b0, flip_add};

    // Per-mode trigger, using the pre-shift LFSR value and current phase.
    always_comb begin
        trig = 1'b0;
        case (mode_i)
            2'd1:    trig = (phase == PHASE_TRIG);
            2'd2:    trig = ((lfsr & TRIG_MASK) == 16'h0000);
            2'd3:    trig = ((lfsr & TRIG_MASK) == 16'h0000);
            default: trig = 1'b0;
        endcase
    end

    // Next-state logic: decide corruption and burst bookkeeping per symbol event.
    always_comb begin
        state_nx    = state;
        rem_nx      = rem;
        corrupt     = 1'b0;
        burst_start = 1'b0;
        if (valid_i) begin
            case (state)
                S_IDLE: begin
                    if (inj_en && trig) begin
                        corrupt     = 1'b1;
                        burst_start = 1'b1;
                        if (((mode_i == 2'd1) || (mode_i == 2'd3)) && (BURST_LEN > 1)) begin
                            state_nx = S_BURST;
                            rem_nx   = REM_INIT;
                        end
                    end
                end
                S_BURST: begin
                    // A trigger here is ignored; the running burst owns the symbol.
                    if (inj_en) begin
                        corrupt = 1'b1;
                        rem_nx  = rem - 1'b1;
                        if (rem == RW'(1)) begin
                            state_nx = S_IDLE;
                        end
                    end else begin
                        state_nx = S_IDLE;
                        rem_nx   = '0;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    rem_nx   = '0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            rem   <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // Datapath: outputs, phase, LFSR and saturating counters advance on symbol events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o    <= 1'b0;
            sym_o      <= '0;
            err_o      <= 1'b0;
            sym_ct_o   <= '0;
            flip_ct_o  <= '0;
            burst_ct_o <= '0;
            phase      <= '0;
            lfsr       <= SEED;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sym_o    <= corrupt ? (sym_i ^ mask_i) : sym_i;
                err_o    <= corrupt;
                phase    <= phase_nx;
                lfsr     <= lfsr_nx;
                sym_ct_o <= (sym_ct_o == '1) ? sym_ct_o : sym_ct_o + 32'd1;
                if (corrupt) begin
                    flip_ct_o <= flip_sum[32] ? '1 : flip_sum[31:0];
                end
                if (burst_start && (burst_ct_o != '1)) begin
                    burst_ct_o <= burst_ct_o + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_channel_model.sv
// Directed bench for viterbi_channel_model. Four instances share the input
// stimulus with different parameter sets; each step checks one of them.
module tb_viterbi_channel_model;

    localparam int W = 2;
    localparam int NS [4] = '{5, 0, 0, 0};
    localparam int BL [4] = '{2, 2, 3, 4};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   mode_i = 2'd0;
    logic [W-1:0] mask_i = '0;
    logic         valid_i = 1'b0;
    logic [W-1:0] sym_i = '0;

    logic         valid_o    [4];
    logic [W-1:0] sym_o      [4];
    logic         err_o      [4];
    logic [31:0]  sym_ct_o   [4];
    logic [31:0]  flip_ct_o  [4];
    logic [15:0]  burst_ct_o [4];
    logic         dbg_state_o[4];
    logic [15:0]  dbg_lfsr_o [4];

    int n_tests = 0;
    int n_fail  = 0;

    logic [W:0] exp_q[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        viterbi_channel_model #(
            .W(W), .N(NS[g]), .PERIOD(32), .BURST_LEN(BL[g]),
            .WINDOW(256), .SEED(16'hACE1)
        ) u_dut (
            .clk(clk), .rst(rst), .mode_i(mode_i), .mask_i(mask_i),
            .valid_i(valid_i), .sym_i(sym_i),
            .valid_o(valid_o[g]), .sym_o(sym_o[g]), .err_o(err_o[g]),
            .sym_ct_o(sym_ct_o[g]), .flip_ct_o(flip_ct_o[g]),
            .burst_ct_o(burst_ct_o[g]), .dbg_state_o(dbg_state_o[g]),
            .dbg_lfsr_o(dbg_lfsr_o[g])
        );
    end

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        valid_i = 1'b0;
        mode_i  = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive one cycle at the negedge, then sample 1 time unit after the posedge.
    task automatic send(input logic v, input logic [W-1:0] s);
        @(negedge clk);
        valid_i = v;
        sym_i   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input int d, input string tag,
                                  input int sc, input int fc, input int bc);
        check({tag, "_sym_ct"},   sym_ct_o[d],          32'(sc));
        check({tag, "_flip_ct"},  flip_ct_o[d],         32'(fc));
        check({tag, "_burst_ct"}, {16'h0, burst_ct_o[d]}, 32'(bc));
    endtask

    // Run n contiguous symbols counting mod 4 on instance d; corrupted symbol
    // indices are given by the rule selected with kind.
    task automatic run_contig(input int d, input string tag, input int n, input int kind);
        logic [W:0]   got, exp;
        logic [W-1:0] s;
        logic         c;
        for (int i = 0; i < n; i++) begin
            s = W'(i % 4);
            case (kind)
                1:       c = ((i % 32) >= 30) && (i < 256);
                2:       c = (i < 256);
                3:       c = 1'b1;
                default: c = 1'b0;
            endcase
            exp_q.push_back({c, c ? (s ^ mask_i) : s});
            send(1'b1, s);
            got = {err_o[d], sym_o[d]};
            exp = exp_q.pop_front();
            check({tag, "_sym"}, 32'(got), 32'(exp));
        end
    endtask

    initial begin : main
        logic [W:0]   last_exp;
        logic [W:0]   got, exp;
        logic [W-1:0] s;
        logic         v, c;

        // Reset state while rst is held low.
        #12;
        check("rst_valid", 32'(valid_o[0]), 32'd0);
        check("rst_sym",   32'(sym_o[0]),   32'd0);
        check("rst_lfsr",  32'(dbg_lfsr_o[0]), 32'hACE1);
        check_counters(0, "rst", 0, 0, 0);
        do_reset();

        // Mode 0: clean pass-through; first LFSR step ACE1 -> E270.
        mode_i = 2'd0;
        mask_i = 2'b11;
        send(1'b1, 2'd0);
        check("m0_first_sym", 32'(sym_o[0]), 32'd0);
        check("m0_first_err", 32'(err_o[0]), 32'd0);
        check("m0_lfsr_step", 32'(dbg_lfsr_o[0]), 32'hE270);
        do_reset();
        run_contig(0, "m0", 300, 0);
        check_counters(0, "m0", 300, 0, 0);

        // Mode 1 periodic bursts at 30,31 mod 32 inside the window.
        do_reset();
        mode_i = 2'd1;
        mask_i = 2'b11;
        run_contig(0, "m1", 300, 1);
        check_counters(0, "m1", 300, 32, 8);

        // Mode 2 with N=0: every in-window symbol is hit.
        do_reset();
        mode_i = 2'd2;
        mask_i = 2'b01;
        run_contig(1, "m2", 260, 2);
        check_counters(1, "m2", 260, 256, 256);

        // Mode 3 with N=0, BURST_LEN=3: back-to-back bursts.
        do_reset();
        mode_i = 2'd3;
        mask_i = 2'b10;
        run_contig(2, "m3", 256, 3);
        check_counters(2, "m3", 256, 256, 86);

        // Mode 1 with valid toggling: corruption follows symbol index only.
        do_reset();
        mode_i   = 2'd1;
        mask_i   = 2'b11;
        last_exp = '0;
        for (int i = 0; i < 600; i++) begin
            v = (i % 2) == 0;
            if (v) begin
                s = W'((i / 2) % 4);
                c = (((i / 2) % 32) >= 30) && ((i / 2) < 256);
                exp_q.push_back({c, c ? (s ^ mask_i) : s});
            end else begin
                s = W'($urandom_range(0, 3));
            end
            send(v, s);
            check("tog_valid", 32'(valid_o[0]), 32'(v));
            got = {err_o[0], sym_o[0]};
            if (v) begin
                exp      = exp_q.pop_front();
                last_exp = exp;
                check("tog_sym", 32'(got), 32'(exp));
            end else begin
                check("tog_hold", 32'(got), 32'(last_exp));
            end
        end
        check_counters(0, "tog", 300, 32, 8);

        // Mode 3 burst cut short by a switch to mode 0.
        do_reset();
        mode_i = 2'd3;
        mask_i = 2'b11;
        send(1'b1, 2'd1);
        check("cut_s0_sym",   32'(sym_o[3]), 32'd2);
        check("cut_s0_err",   32'(err_o[3]), 32'd1);
        check("cut_s0_state", 32'(dbg_state_o[3]), 32'd1);
        mode_i = 2'd0;
        send(1'b1, 2'd2);
        check("cut_s1_sym",   32'(sym_o[3]), 32'd2);
        check("cut_s1_err",   32'(err_o[3]), 32'd0);
        check("cut_s1_state", 32'(dbg_state_o[3]), 32'd0);
        check_counters(3, "cut", 2, 2, 1);

        // Mode 3 burst cut short by an asynchronous reset mid-cycle.
        do_reset();
        mode_i = 2'd3;
        send(1'b1, 2'd1);
        check("ar_s0_state", 32'(dbg_state_o[3]), 32'd1);
        @(negedge clk);
        valid_i = 1'b1;
        sym_i   = 2'd2;
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 32'(valid_o[3]), 32'd0);
        check("ar_sym",   32'(sym_o[3]),   32'd0);
        check("ar_err",   32'(err_o[3]),   32'd0);
        check("ar_state", 32'(dbg_state_o[3]), 32'd0);
        check("ar_lfsr",  32'(dbg_lfsr_o[3]), 32'hACE1);
        check_counters(3, "ar", 0, 0, 0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
